// File: rtl/add_unit.sv
// One-bit full-adder slice with carry-lookahead generate/propagate outputs.
// Define ADD_REG_OUT_EN to add the registered output stage and the saturating carry counter.
module add_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ai,
  input  logic             bi,
  input  logic             ci,
  input  logic             in_valid,
  output logic             si,
  output logic             co,
  output logic             Gi,
  output logic             Pi,
  output logic             sum_q,
  output logic             carry_q,
  output logic             g_q,
  output logic             p_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  logic w_p;
  logic w_g;
  logic w_s;
  logic w_c;

  // Pi must be XOR so that Gi and Pi are mutually exclusive for the CLA tree.
  assign w_p = ai ^ bi;
  assign w_g = ai & bi;
  assign w_s = w_p ^ ci;
  assign w_c = w_g | (w_p & ci);

  assign si = w_s;
  assign co = w_c;
  assign Gi = w_g;
  assign Pi = w_p;

`ifdef ADD_REG_OUT_EN
  logic             r_sum;
  logic             r_carry;
  logic             r_g;
  logic             r_p;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
      r_g     <= 1'b0;
      r_p     <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_s;
        r_carry <= w_c;
        r_g     <= w_g;
        r_p     <= w_p;
      end
      // Counter sticks at all-ones rather than wrapping.
      if (in_valid && w_c && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sum_q     = r_sum;
  assign carry_q   = r_carry;
  assign g_q       = r_g;
  assign p_q       = r_p;
  assign out_valid = r_valid;
  assign carry_cnt = r_cnt;
`else
  logic w_unused;

  assign w_unused  = clk ^ rst ^ in_valid;
  assign sum_q     = 1'b0;
  assign carry_q   = 1'b0;
  assign g_q       = 1'b0;
  assign p_q       = 1'b0;
  assign out_valid = 1'b0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_add_unit.sv
// Self-checking bench for add_unit: truth-table sweep, registered-stage sequences, random run.
// Expected registered values follow ADD_REG_OUT_EN (all zero when it is undefined).
`timescale 1ns/1ps
module tb_add_unit;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ADD_REG_OUT_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  typedef struct {
    logic ci;
    logic ai;
    logic bi;
    logic co;
    logic si;
  } vec_t;

  logic clk = 1'b0;
  logic clkEn = 1'b0;
  logic rst = 1'b1;
  logic ai = 1'b0;
  logic bi = 1'b0;
  logic ci = 1'b0;
  logic in_valid = 1'b0;
  logic si, co, Gi, Pi;
  logic sum_q, carry_q, g_q, p_q, out_valid;
  logic [CNT_W-1:0] carry_cnt;

  int checks = 0;
  int errors = 0;

  // Model state for the registered stage
  int mSum = 0;
  int mCarry = 0;
  int mG = 0;
  int mP = 0;
  int mValid = 0;
  int mCnt = 0;

  add_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ai(ai), .bi(bi), .ci(ci), .in_valid(in_valid),
    .si(si), .co(co), .Gi(Gi), .Pi(Pi),
    .sum_q(sum_q), .carry_q(carry_q), .g_q(g_q), .p_q(p_q),
    .out_valid(out_valid), .carry_cnt(carry_cnt)
  );

  always #5 clk = clkEn ? ~clk : clk;

  task automatic applyStimulus(input logic c, input logic a, input logic b, input logic v);
    ci = c;
    ai = a;
    bi = b;
    in_valid = v;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Combinational checks derived from the arithmetic sum of the three input bits
  task automatic checkComb(input string tag);
    int total;
    total = int'(ai) + int'(bi) + int'(ci);
    checkOutput({tag, ".si"}, int'(si), total % 2);
    checkOutput({tag, ".co"}, int'(co), (total >= 2) ? 1 : 0);
    checkOutput({tag, ".Gi"}, int'(Gi), (ai && bi) ? 1 : 0);
    checkOutput({tag, ".Pi"}, int'(Pi), (ai != bi) ? 1 : 0);
  endtask

  task automatic checkRegs(input string tag, input int es, input int ec, input int eg,
                           input int ep, input int ev, input int en);
    checkOutput({tag, ".sum_q"}, int'(sum_q), REG_EN ? es : 0);
    checkOutput({tag, ".carry_q"}, int'(carry_q), REG_EN ? ec : 0);
    checkOutput({tag, ".g_q"}, int'(g_q), REG_EN ? eg : 0);
    checkOutput({tag, ".p_q"}, int'(p_q), REG_EN ? ep : 0);
    checkOutput({tag, ".out_valid"}, int'(out_valid), REG_EN ? ev : 0);
    checkOutput({tag, ".carry_cnt"}, int'(carry_cnt), REG_EN ? en : 0);
  endtask

  // Model of one rising edge, using the inputs currently applied
  task automatic modelEdge();
    int total;
    total = int'(ai) + int'(bi) + int'(ci);
    mValid = int'(in_valid);
    if (in_valid) begin
      mSum = total % 2;
      mCarry = (total >= 2) ? 1 : 0;
      mG = (ai && bi) ? 1 : 0;
      mP = (ai != bi) ? 1 : 0;
      if (total >= 2 && mCnt < CNT_MAX) mCnt++;
    end
  endtask

  task automatic modelReset();
    mSum = 0; mCarry = 0; mG = 0; mP = 0; mValid = 0; mCnt = 0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    vec_t vecs[9];
    int expCnt[6];
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    expCnt = '{1, 2, 3, 3, 3, 3};

    #1;
    checkRegs("reset", 0, 0, 0, 0, 0, 0);

    // Clockless sweep against the truth table, with reset released
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].ci, vecs[i].ai, vecs[i].bi, 1'b1);
      #50;
      checkOutput($sformatf("tt%0d.co", i), int'(co), int'(vecs[i].co));
      checkOutput($sformatf("tt%0d.si", i), int'(si), int'(vecs[i].si));
      checkOutput($sformatf("tt%0d.Gi", i), int'(Gi), int'(vecs[i].ai & vecs[i].bi));
      checkOutput($sformatf("tt%0d.Pi", i), int'(Pi), int'(vecs[i].ai ^ vecs[i].bi));
    end
    checkRegs("noclock", 0, 0, 0, 0, 0, 0);

    // Generate and propagate are exclusive when both operands are 1
    for (int c = 0; c < 2; c++) begin
      applyStimulus(c[0], 1'b1, 1'b1, 1'b0);
      #10;
      checkOutput($sformatf("gp%0d.Gi", c), int'(Gi), 1);
      checkOutput($sformatf("gp%0d.Pi", c), int'(Pi), 0);
      checkOutput($sformatf("gp%0d.co", c), int'(co), 1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    clkEn = 1'b1;
    pulseReset();

    // One valid 111, then idle: one-cycle latency then hold
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkRegs("lat1", 1, 1, 1, 0, 1, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkRegs("lat2", 1, 1, 1, 0, 0, 1);

    // Saturation of a 2-bit counter on six back-to-back carries
    pulseReset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat%0d.carry_cnt", i), int'(carry_cnt), REG_EN ? expCnt[i] : 0);
    end

    // Asynchronous reset asserted between edges
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
    end
    #1;
    checkRegs("prerst", 0, 1, 0, 1, 1, 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkRegs("midrst", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkComb("rstcomb");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkRegs("postrst", 1, 1, 1, 0, 1, 1);

    // Random run against the arithmetic model
    pulseReset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      #1;
      checkComb("rnd");
      @(posedge clk);
      modelEdge();
      #1;
      checkRegs("rnd", mSum, mCarry, mG, mP, mValid, mCnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
